// File: rtl/fpga_issue_ctrl.sv
// fpga_issue_ctrl: allocation and issue control for the FPGA-accelerator
// reservation station. Allocates free entries to two dispatch slots,
// picks a ready entry round-robin, launches it on the accelerator and
// tracks it through completion or a branch-mispredict squash.
// Optional feature: define FPGA_TIMEOUT_EN to enable the EXEC/DRAIN
// timeout watchdog (sticky timeout_err, forced kill and squash).
module fpga_issue_ctrl #(
  parameter int ENT_NUM     = 2,
  parameter int ENT_SEL     = 1,
  parameter int SPECTAG_LEN = 5,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ENT_NUM-1:0]     busyvec,
  input  logic [ENT_NUM-1:0]     ready,
  input  logic                   req1,
  input  logic                   req2,
  input  logic [SPECTAG_LEN-1:0] issue_spectag,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  input  logic                   fu_ready,
  input  logic                   fu_done,
  output logic                   we1,
  output logic                   we2,
  output logic [ENT_SEL-1:0]     waddr1,
  output logic [ENT_SEL-1:0]     waddr2,
  output logic                   stall,
  output logic                   clearbusy,
  output logic [ENT_SEL-1:0]     issueaddr,
  output logic                   fu_start,
  output logic                   fu_kill,
  output logic                   done_valid,
  output logic                   done_squash,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ENT_SEL-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ENT_SEL-1:0]     issued_q, issued_d;
  logic [SPECTAG_LEN-1:0] act_tag_q, act_tag_d;
  logic                   clearbusy_q, clearbusy_d;
  logic                   fu_start_q, fu_start_d;
  logic                   fu_kill_q, fu_kill_d;
  logic                   done_valid_q, done_valid_d;
  logic                   done_squash_q, done_squash_d;

  logic [ENT_SEL-1:0]     freeFirst, freeSecond;
  logic                   freeFirstFound, freeSecondFound;
  logic                   lackEntries;
  logic [ENT_SEL-1:0]     candIdx;
  logic                   candFound;
  logic [ENT_SEL-1:0]     rrNext;
  logic                   issueGo;
  logic                   killHit;

`ifdef FPGA_TIMEOUT_EN
  logic [15:0]            cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   timeoutHit;
`endif

  // Find the two lowest-index free entries for the dispatch slots.
  always_comb begin
    freeFirst       = '0;
    freeSecond      = '0;
    freeFirstFound  = 1'b0;
    freeSecondFound = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busyvec[i]) begin
        if (!freeFirstFound) begin
          freeFirst      = ENT_SEL'(i);
          freeFirstFound = 1'b1;
        end else if (!freeSecondFound) begin
          freeSecond      = ENT_SEL'(i);
          freeSecondFound = 1'b1;
        end
      end
    end
  end

  // A lone req2 uses the first free entry, so it only needs one slot.
  assign lackEntries = (req1 && req2) ? !freeSecondFound :
                       (req1 || req2) ? !freeFirstFound  : 1'b0;
  assign stall  = lackEntries | prmiss | prsuccess;
  assign we1    = req1 & ~stall;
  assign we2    = req2 & ~stall;
  assign waddr1 = freeFirst;
  assign waddr2 = (req2 && !req1) ? freeFirst : freeSecond;

  // Round-robin search for an occupied, operand-ready entry from rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    candFound = 1'b0;
    candIdx   = rr_ptr_q;
    for (int i = 0; i < ENT_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= ENT_NUM) idx = idx - ENT_NUM;
      if (!candFound && busyvec[idx] && ready[idx]) begin
        candFound = 1'b1;
        candIdx   = ENT_SEL'(idx);
      end
    end
  end

  assign rrNext    = (candIdx == ENT_SEL'(ENT_NUM - 1)) ? '0 : candIdx + ENT_SEL'(1);
  assign issueGo   = (state_q == IDLE) && candFound && fu_ready && !prmiss;
  assign killHit   = prmiss && (|(act_tag_q & specfixtag));
  // While an operation is in flight the station still sees the issued entry.
  assign issueaddr = (state_q == IDLE) ? candIdx : issued_q;

`ifdef FPGA_TIMEOUT_EN
  // Count in-flight cycles, restarting at each issue and saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (issueGo) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign timeoutHit = (state_q != IDLE) &&
                      (({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT));
`endif

  // Next-state logic and one-cycle pulse generation for the issue FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    issued_d      = issued_q;
    act_tag_d     = act_tag_q;
    clearbusy_d   = 1'b0;
    fu_start_d    = 1'b0;
    fu_kill_d     = 1'b0;
    done_valid_d  = 1'b0;
    done_squash_d = 1'b0;
`ifdef FPGA_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (issueGo) begin
          clearbusy_d = 1'b1;
          fu_start_d  = 1'b1;
          act_tag_d   = issue_spectag;
          rr_ptr_d    = rrNext;
          issued_d    = candIdx;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (killHit) begin
          fu_kill_d = 1'b1;
          if (fu_done) begin
            done_squash_d = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (fu_done) begin
          done_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          if (prsuccess && (prtag == act_tag_q)) begin
            act_tag_d = '0;
          end
`ifdef FPGA_TIMEOUT_EN
          if (timeoutHit) begin
            fu_kill_d     = 1'b1;
            done_squash_d = 1'b1;
            timeout_d     = 1'b1;
            state_d       = IDLE;
          end
`endif
        end
      end
      DRAIN: begin
        if (fu_done) begin
          done_squash_d = 1'b1;
          state_d       = IDLE;
        end
`ifdef FPGA_TIMEOUT_EN
        else if (timeoutHit) begin
          fu_kill_d     = 1'b1;
          done_squash_d = 1'b1;
          timeout_d     = 1'b1;
          state_d       = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pulse registers; reset abandons any in-flight operation silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      issued_q      <= '0;
      act_tag_q     <= '0;
      clearbusy_q   <= 1'b0;
      fu_start_q    <= 1'b0;
      fu_kill_q     <= 1'b0;
      done_valid_q  <= 1'b0;
      done_squash_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      issued_q      <= issued_d;
      act_tag_q     <= act_tag_d;
      clearbusy_q   <= clearbusy_d;
      fu_start_q    <= fu_start_d;
      fu_kill_q     <= fu_kill_d;
      done_valid_q  <= done_valid_d;
      done_squash_q <= done_squash_d;
    end
  end

`ifdef FPGA_TIMEOUT_EN
  // Cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign clearbusy   = clearbusy_q;
  assign fu_start    = fu_start_q;
  assign fu_kill     = fu_kill_q;
  assign done_valid  = done_valid_q;
  assign done_squash = done_squash_q;

endmodule

// File: tb/tb_fpga_issue_ctrl.sv
// tb_fpga_issue_ctrl: directed self-checking bench for fpga_issue_ctrl
// (ENT_NUM=2, SPECTAG_LEN=5, TIMEOUT=8). Builds with or without
// FPGA_TIMEOUT_EN; the timeout expectations follow the same macro.
module tb_fpga_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] busyvec, ready;
  logic       req1, req2;
  logic [4:0] issue_spectag, prtag, specfixtag;
  logic       prmiss, prsuccess, fu_ready, fu_done;
  logic       we1, we2, stall, clearbusy, fu_start, fu_kill;
  logic       done_valid, done_squash, timeout_err;
  logic [0:0] waddr1, waddr2, issueaddr;

  int testsRun = 0;
  int testsFailed = 0;

  fpga_issue_ctrl #(
    .ENT_NUM(2), .ENT_SEL(1), .SPECTAG_LEN(5), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .busyvec(busyvec), .ready(ready),
    .req1(req1), .req2(req2), .issue_spectag(issue_spectag),
    .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .specfixtag(specfixtag), .fu_ready(fu_ready), .fu_done(fu_done),
    .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
    .stall(stall), .clearbusy(clearbusy), .issueaddr(issueaddr),
    .fu_start(fu_start), .fu_kill(fu_kill), .done_valid(done_valid),
    .done_squash(done_squash), .timeout_err(timeout_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] busy, input logic [1:0] rdy,
                               input logic r1, input logic r2);
    busyvec = busy;
    ready   = rdy;
    req1    = r1;
    req2    = r2;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    busyvec = 2'b00; ready = 2'b00; req1 = 0; req2 = 0;
    issue_spectag = '0; prtag = '0; specfixtag = '0;
    prmiss = 0; prsuccess = 0; fu_ready = 0; fu_done = 0;
    #1;
    checkOutput("rst_clearbusy", clearbusy, 0);
    checkOutput("rst_fu_start", fu_start, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_issueaddr", issueaddr, 0);

    // Clock edges while held in reset must not issue.
    busyvec = 2'b11; ready = 2'b11; fu_ready = 1;
    step();
    step();
    checkOutput("rst_hold_clearbusy", clearbusy, 0);
    checkOutput("rst_hold_fu_start", fu_start, 0);
    fu_ready = 0;
    reset = 1'b1;

    // Allocation vectors.
    applyStimulus(2'b00, 2'b00, 1, 1);
    checkOutput("alloc00_we1", we1, 1);
    checkOutput("alloc00_we2", we2, 1);
    checkOutput("alloc00_waddr1", waddr1, 0);
    checkOutput("alloc00_waddr2", waddr2, 1);
    checkOutput("alloc00_stall", stall, 0);
    applyStimulus(2'b01, 2'b00, 1, 1);
    checkOutput("alloc01_stall", stall, 1);
    checkOutput("alloc01_we1", we1, 0);
    checkOutput("alloc01_we2", we2, 0);
    applyStimulus(2'b01, 2'b00, 1, 0);
    checkOutput("alloc01_one_stall", stall, 0);
    checkOutput("alloc01_one_waddr1", waddr1, 1);
    applyStimulus(2'b10, 2'b00, 0, 1);
    checkOutput("alloc10_r2_we2", we2, 1);
    checkOutput("alloc10_r2_waddr2", waddr2, 0);
    applyStimulus(2'b11, 2'b00, 1, 0);
    checkOutput("alloc11_stall", stall, 1);
    prsuccess = 1;
    applyStimulus(2'b00, 2'b00, 1, 0);
    checkOutput("alloc_prsucc_stall", stall, 1);
    checkOutput("alloc_prsucc_we1", we1, 0);
    prsuccess = 0;
    applyStimulus(2'b00, 2'b00, 0, 0);

    // Candidate present but prmiss blocks issue.
    prmiss = 1; fu_ready = 1;
    applyStimulus(2'b11, 2'b11, 0, 0);
    checkOutput("idle_issueaddr", issueaddr, 0);
    step();
    checkOutput("prmiss_no_clearbusy", clearbusy, 0);
    checkOutput("prmiss_no_fu_start", fu_start, 0);

    // Issue entry 0, complete it, then round-robin picks entry 1.
    prmiss = 0;
    step();
    checkOutput("issue0_clearbusy", clearbusy, 1);
    checkOutput("issue0_fu_start", fu_start, 1);
    checkOutput("issue0_addr", issueaddr, 0);
    step();
    checkOutput("issue0_clearbusy_1cyc", clearbusy, 0);
    checkOutput("issue0_fu_start_1cyc", fu_start, 0);
    checkOutput("exec_no_done", done_valid, 0);
    fu_done = 1;
    step();
    checkOutput("done0_valid", done_valid, 1);
    checkOutput("done0_squash", done_squash, 0);
    fu_done = 0; issue_spectag = 5'b00100;
    #1;
    checkOutput("rr_next_addr", issueaddr, 1);
    step();
    checkOutput("issue1_fu_start", fu_start, 1);
    checkOutput("issue1_clearbusy", clearbusy, 1);
    checkOutput("issue1_addr", issueaddr, 1);
    checkOutput("issue1_done_valid", done_valid, 0);
    fu_ready = 0;

    // Mispredict kill, DRAIN ignores further misses, squash on completion.
    prmiss = 1; specfixtag = 5'b00110;
    step();
    checkOutput("kill_fu_kill", fu_kill, 1);
    checkOutput("kill_no_squash_yet", done_squash, 0);
    prmiss = 0;
    step();
    checkOutput("kill_pulse_1cyc", fu_kill, 0);
    prmiss = 1;
    step();
    checkOutput("drain_prmiss_ignored", fu_kill, 0);
    prmiss = 0;
    step();
    fu_done = 1;
    step();
    checkOutput("drain_done_squash", done_squash, 1);
    checkOutput("drain_no_valid", done_valid, 0);
    fu_done = 0;
    #1;
    checkOutput("drain_rr_addr", issueaddr, 0);

    // fu_done while idle does nothing.
    fu_done = 1;
    step();
    checkOutput("idle_done_valid", done_valid, 0);
    checkOutput("idle_done_squash", done_squash, 0);
    fu_done = 0;

    // A resolved-correct branch protects the operation from later misses.
    issue_spectag = 5'b00010; fu_ready = 1;
    step();
    checkOutput("issue2_fu_start", fu_start, 1);
    fu_ready = 0; prsuccess = 1; prtag = 5'b00010;
    step();
    prsuccess = 0; prmiss = 1; specfixtag = 5'b00010;
    step();
    checkOutput("prsucc_no_kill", fu_kill, 0);
    prmiss = 0; fu_done = 1;
    step();
    checkOutput("prsucc_done_valid", done_valid, 1);
    checkOutput("prsucc_no_squash", done_squash, 0);
    fu_done = 0;

    // Kill coinciding with completion squashes and returns to IDLE.
    issue_spectag = 5'b00001; fu_ready = 1;
    step();
    checkOutput("issue3_fu_start", fu_start, 1);
    checkOutput("issue3_addr", issueaddr, 1);
    fu_ready = 0; prmiss = 1; specfixtag = 5'b00001; fu_done = 1;
    step();
    checkOutput("coinc_fu_kill", fu_kill, 1);
    checkOutput("coinc_squash", done_squash, 1);
    checkOutput("coinc_no_valid", done_valid, 0);
    prmiss = 0; fu_done = 0;
    step();
    checkOutput("coinc_idle_squash", done_squash, 0);
    checkOutput("coinc_idle_kill", fu_kill, 0);

    // Operation that never completes: watchdog behaviour.
    issue_spectag = 5'b00000; fu_ready = 1;
    step();
    checkOutput("issue4_fu_start", fu_start, 1);
    checkOutput("issue4_addr", issueaddr, 0);
    fu_ready = 0;
    for (int i = 0; i < 7; i++) step();
    checkOutput("pre_timeout_kill", fu_kill, 0);
    step();
`ifdef FPGA_TIMEOUT_EN
    checkOutput("timeout_err_set", timeout_err, 1);
    checkOutput("timeout_fu_kill", fu_kill, 1);
    checkOutput("timeout_squash", done_squash, 1);
    step();
    checkOutput("timeout_err_sticky", timeout_err, 1);
    checkOutput("timeout_kill_1cyc", fu_kill, 0);
`else
    checkOutput("no_timeout_err", timeout_err, 0);
    checkOutput("no_timeout_kill", fu_kill, 0);
    fu_done = 1;
    step();
    checkOutput("late_done_valid", done_valid, 1);
    fu_done = 0;
`endif

    // Reset in the middle of EXEC abandons the operation without a kill.
    fu_ready = 1;
    applyStimulus(2'b01, 2'b01, 0, 0);
    step();
    checkOutput("issue5_fu_start", fu_start, 1);
    checkOutput("issue5_addr", issueaddr, 0);
    fu_ready = 0;
    step();
    reset = 1'b0;
    #1;
    checkOutput("async_rst_kill", fu_kill, 0);
    checkOutput("async_rst_timeout", timeout_err, 0);
    applyStimulus(2'b11, 2'b11, 0, 0);
    checkOutput("async_rst_rr", issueaddr, 0);
    step();
    checkOutput("in_rst_kill", fu_kill, 0);
    checkOutput("in_rst_clearbusy", clearbusy, 0);
    reset = 1'b1; fu_done = 1;
    step();
    checkOutput("post_rst_done_valid", done_valid, 0);
    checkOutput("post_rst_done_squash", done_squash, 0);
    fu_done = 0; fu_ready = 1;
    step();
    checkOutput("post_rst_fu_start", fu_start, 1);
    checkOutput("post_rst_addr", issueaddr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
